or_response_checker: RTL and testbench

Synthesizable response checker that sits directly downstream of the 2-input OR-gate DUT. It samples the DUT's A, B and Y nets, recomputes the expected Y = A | B, and counts matches and mismatches over a programmed number of transactions. It reports a done/pass status to the bench, replacing by-eye inspection of `$monitor` output with a self-checking stage.

---
 rtl/or_response_checker.sv | 125 ++++++++++++
 tb/tb_or_response_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/or_response_checker.sv
// Checks Y == A|B on sampled DUT nets and counts pass/fail over a programmed number of samples.
// Optional first-error capture is built when OR_CHK_FIRST_ERR_CAPTURE_EN is defined.
module or_response_checker #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] txn_target,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             all_pass,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_y
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] target_q, idx_q, pass_q, fail_q;
  logic             pipe_vld_q;
  logic [WIDTH-1:0] a_q, b_q, y_q;
  logic             start_acc, accept, last_acc, match;
  logic [CNT_W:0]   idx_inc;

  assign start_acc = start && (state == IDLE || state == DONE);
  assign accept    = (state == RUN) && in_valid;
  assign idx_inc   = {1'b0, idx_q} + {{CNT_W{1'b0}}, 1'b1};
  assign last_acc  = accept && (idx_inc == {1'b0, target_q});
  assign match     = (y_q == (a_q | b_q));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (txn_target == '0) ? DONE : RUN;
      RUN:        if (last_acc) state_nxt = DRAIN;
      DRAIN:      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q   <= '0;
      idx_q      <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      pipe_vld_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      y_q        <= '0;
    end else begin
      pipe_vld_q <= accept;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
        y_q <= in_y;
        if (idx_q != CNT_MAX) idx_q <= idx_inc[CNT_W-1:0];
      end
      // A start is only taken outside RUN/DRAIN, so it never collides with a retiring sample.
      if (start_acc) begin
        target_q <= txn_target;
        idx_q    <= '0;
        pass_q   <= '0;
        fail_q   <= '0;
      end else if (pipe_vld_q) begin
        if (match) begin
          if (pass_q != CNT_MAX) pass_q <= pass_q + 1'b1;
        end else begin
          if (fail_q != CNT_MAX) fail_q <= fail_q + 1'b1;
        end
      end
    end
  end

`ifdef OR_CHK_FIRST_ERR_CAPTURE_EN
  logic [CNT_W-1:0] pipe_idx_q, err_idx_q;
  logic [WIDTH-1:0] err_y_q;

  // fail_q is still zero exactly when the retiring mismatch is the first of the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_idx_q <= '0;
      err_idx_q  <= '0;
      err_y_q    <= '0;
    end else begin
      if (accept) pipe_idx_q <= idx_q;
      if (start_acc) begin
        err_idx_q <= '0;
        err_y_q   <= '0;
      end else if (pipe_vld_q && !match && fail_q == '0) begin
        err_idx_q <= pipe_idx_q;
        err_y_q   <= y_q;
      end
    end
  end

  assign first_err_idx = err_idx_q;
  assign first_err_y   = err_y_q;
`else
  assign first_err_idx = '0;
  assign first_err_y   = '0;
`endif

  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign all_pass = done && (fail_q == '0);

endmodule

// File: tb/tb_or_response_checker.sv
// Bench for or_response_checker: table-driven runs, hand-written corner sequences, randomized runs vs a count model.
module tb_or_response_checker;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_a, in_b, in_y;
  logic [15:0] txn_target;
  logic        busy, done, all_pass, first_err_y;
  logic [15:0] pass_cnt, fail_cnt, first_err_idx;
  logic        s_busy, s_done, s_all_pass, s_first_err_y;
  logic [1:0]  s_pass, s_fail, s_first_err_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  or_response_checker #(.WIDTH(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .txn_target(txn_target), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_y(in_y), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .all_pass(all_pass),
    .first_err_idx(first_err_idx), .first_err_y(first_err_y));

  or_response_checker #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .txn_target(txn_target[1:0]), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_y(in_y), .busy(s_busy), .done(s_done),
    .pass_cnt(s_pass), .fail_cnt(s_fail), .all_pass(s_all_pass),
    .first_err_idx(s_first_err_idx), .first_err_y(s_first_err_y));

  typedef struct {
    logic a, b, y;
    int   exp_pass, exp_fail;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int t);
    start = 1'b1;
    txn_target = 16'(t);
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input logic v, input logic a, input logic b, input logic y);
    in_valid = v;
    in_a = a;
    in_b = b;
    in_y = y;
  endtask

  task automatic chk_first(input string name, input int idx, input logic y);
`ifdef OR_CHK_FIRST_ERR_CAPTURE_EN
    chk({name, "_idx"}, 32'(first_err_idx), 32'(idx));
    chk({name, "_y"}, 32'(first_err_y), 32'(y));
`else
    chk({name, "_idx"}, 32'(first_err_idx), 32'd0);
    chk({name, "_y"}, 32'(first_err_y), 32'd0);
`endif
  endtask

  // Four back-to-back samples from the table; counts lag acceptance by one edge.
  task automatic run_table(input int base);
    do_start(4);
    chk("tbl_busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, tbl[base+i].a, tbl[base+i].b, tbl[base+i].y);
      tick();
      if (i > 0) begin
        chk("tbl_pass_running", 32'(pass_cnt), 32'(tbl[base+i-1].exp_pass));
        chk("tbl_fail_running", 32'(fail_cnt), 32'(tbl[base+i-1].exp_fail));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("tbl_drain_not_done", 32'(done), 32'd0);
    chk("tbl_drain_busy", 32'(busy), 32'd1);
    tick();
    chk("tbl_done", 32'(done), 32'd1);
    chk("tbl_busy_low", 32'(busy), 32'd0);
    chk("tbl_pass_final", 32'(pass_cnt), 32'(tbl[base+3].exp_pass));
    chk("tbl_fail_final", 32'(fail_cnt), 32'(tbl[base+3].exp_fail));
    chk("tbl_all_pass", 32'(all_pass), 32'(tbl[base+3].exp_fail == 0));
  endtask

  initial begin
    int acc, target, exp_pass, exp_fail, exp_idx, cyc;
    logic exp_y, a, b, v, bad;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 2, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 3, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 4, 0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1, 0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 2, 0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 2, 1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 3, 1};

    rst = 1'b1;
    start = 1'b0;
    txn_target = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass_cnt), 32'd0);
    chk("rst_fail", 32'(fail_cnt), 32'd0);
    chk("rst_all_pass", 32'(all_pass), 32'd0);
    chk_first("rst_first", 0, 1'b0);

    run_table(0);
    chk_first("exh_first", 0, 1'b0);
    run_table(4);
    chk_first("fault_first", 2, 1'b0);

    // Gapped valid with an ignored start pulse mid-run.
    do_start(3);
    for (int c = 0; c < 6; c++) begin
      drive((c % 2) == 0, 1'b1, 1'b1, 1'b1);
      start = (c == 1);
      txn_target = 16'd7;
      tick();
      if (c == 2) chk("gap_not_done_mid", 32'(done), 32'd0);
      if (c == 4) chk("gap_not_done_last", 32'(done), 32'd0);
    end
    start = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_pass", 32'(pass_cnt), 32'd3);
    chk("gap_fail", 32'(fail_cnt), 32'd0);

    // Zero target: straight to DONE, later valids ignored.
    do_start(0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_all_pass", 32'(all_pass), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("zero_pass", 32'(pass_cnt), 32'd0);
    chk("zero_fail", 32'(fail_cnt), 32'd0);

    // Narrow counters: two pass runs cleared between, then an all-fail run.
    for (int r = 0; r < 3; r++) begin
      do_start(3);
      chk("sat_cleared_pass", 32'(s_pass), 32'd0);
      chk("sat_cleared_fail", 32'(s_fail), 32'd0);
      for (int i = 0; i < 3; i++) begin
        a = i[0];
        b = i[1];
        drive(1'b1, a, b, (r == 2) ? ~(a | b) : (a | b));
        tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("sat_done", 32'(s_done), 32'd1);
      chk("sat_pass", 32'(s_pass), (r == 2) ? 32'd0 : 32'd3);
      chk("sat_fail", 32'(s_fail), (r == 2) ? 32'd3 : 32'd0);
    end

    // Reset mid-run with a sample in flight, then a fresh run of 2.
    do_start(4);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_pass", 32'(pass_cnt), 32'd0);
    chk("mrst_fail", 32'(fail_cnt), 32'd0);
    chk("mrst_all_pass", 32'(all_pass), 32'd0);
    chk_first("mrst_first", 0, 1'b0);
    do_start(2);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mrst_new_done", 32'(done), 32'd1);
    chk("mrst_new_pass", 32'(pass_cnt), 32'd2);
    chk("mrst_new_fail", 32'(fail_cnt), 32'd0);

    // Randomized runs against a counting model.
    for (int r = 0; r < 25; r++) begin
      target = 1 + int'($urandom_range(0, 9));
      acc = 0;
      exp_pass = 0;
      exp_fail = 0;
      exp_idx = 0;
      exp_y = 1'b0;
      cyc = 0;
      do_start(target);
      while (acc < target && cyc < 200) begin
        v = ($urandom_range(0, 2) != 0);
        a = 1'($urandom);
        b = 1'($urandom);
        bad = ($urandom_range(0, 4) == 0);
        drive(v, a, b, bad ? ~(a | b) : (a | b));
        tick();
        cyc++;
        if (v) begin
          if (bad) begin
            if (exp_fail == 0) begin
              exp_idx = acc;
              exp_y = ~(a | b);
            end
            exp_fail++;
          end else begin
            exp_pass++;
          end
          acc++;
        end
      end
      if (acc < target) chk("rnd_timeout", 32'(acc), 32'(target));
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("rnd_drain_not_done", 32'(done), 32'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("rnd_done", 32'(done), 32'd1);
      chk("rnd_pass", 32'(pass_cnt), 32'(exp_pass));
      chk("rnd_fail", 32'(fail_cnt), 32'(exp_fail));
      chk("rnd_all_pass", 32'(all_pass), 32'(exp_fail == 0));
      if (exp_fail > 0) chk_first("rnd_first", exp_idx, exp_y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
